// File: rtl/v2f_wide_alu_seq_if.sv
// rtl/v2f_wide_alu_seq_if.sv - request/response bundle for the limb-serial wide ALU
interface v2f_wide_alu_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             out_carry;

  modport master (
    output in_valid, op, is_signed, A, B, out_ready,
    input  in_ready, out_valid, Y, out_carry
  );

  modport slave (
    input  in_valid, op, is_signed, A, B, out_ready,
    output in_ready, out_valid, Y, out_carry
  );
endinterface

// File: rtl/v2f_wide_alu_seq.sv
// rtl/v2f_wide_alu_seq.sv - add/sub/compare for wide operands, one 32-bit limb per clock
module v2f_wide_alu_seq #(
  parameter int WIDTH = 64,
  parameter int LIMB  = 32
) (
  input logic               CLK,
  input logic               ARST,
  v2f_wide_alu_seq_if.slave bus
);
  localparam int NLIMB = (WIDTH + 31) / 32;
  localparam int EW    = NLIMB * 32;
  localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_EQ  = 3'd2;
  localparam logic [2:0] OP_NE  = 3'd3;
  localparam logic [2:0] OP_LT  = 3'd4;
  localparam logic [2:0] OP_LE  = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_GE  = 3'd7;

  if (LIMB != 32 || WIDTH < 1 || WIDTH > 256) begin : g_bad_param
    $error("v2f_wide_alu_seq: LIMB must be 32 and WIDTH within 1..256");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              z_q;
  logic [2:0]        op_q;
  logic              sgn_q;
  logic [WIDTH-1:0]  y_q;
  logic              oc_q;

  logic [31:0]       a_l [NLIMB];
  logic [31:0]       b_l [NLIMB];
  logic [31:0]       r_l [NLIMB];

  logic              accept;
  logic              last;
  logic [EW-1:0]     a_ext, b_ext, a_ld, b_ld;
  logic [31:0]       a_k, b_k, b_in;
  logic              sub;
  logic [32:0]       s;
  logic [EW-1:0]     res_new;
  logic              z_new;
  logic              n_flag, v_flag, lt;
  logic              flag;
  logic              is_cmp;
  logic              add_c;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Y         = y_q;
  assign bus.out_carry = oc_q;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (idx_q == IDXW'(NLIMB - 1));

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last)         state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // GT/LE are evaluated as LT/GE on swapped operands, so only one borrow test exists.
  always_comb begin
    a_ext = bus.is_signed ? EW'($signed(bus.A)) : EW'(bus.A);
    b_ext = bus.is_signed ? EW'($signed(bus.B)) : EW'(bus.B);
    if (bus.op == OP_GT || bus.op == OP_LE) begin
      a_ld = b_ext;
      b_ld = a_ext;
    end else begin
      a_ld = a_ext;
      b_ld = b_ext;
    end
  end

  always_comb begin
    a_k  = a_l[idx_q];
    b_k  = b_l[idx_q];
    sub  = (op_q != OP_ADD);
    b_in = sub ? ~b_k : b_k;
    s    = {1'b0, a_k} + {1'b0, b_in} + {32'd0, carry_q};
    res_new = '0;
    for (int i = 0; i < NLIMB; i++) begin
      res_new[32*i +: 32] = (IDXW'(i) == idx_q) ? s[31:0] : r_l[i];
    end
    z_new  = z_q && (s[31:0] == 32'd0);
    n_flag = s[31];
    v_flag = (a_k[31] == b_in[31]) && (s[31] != a_k[31]);
    lt     = sgn_q ? (n_flag ^ v_flag) : !s[32];
    is_cmp = (op_q != OP_ADD) && (op_q != OP_SUB);
    case (op_q)
      OP_EQ:        flag = z_new;
      OP_NE:        flag = !z_new;
      OP_LT, OP_GT: flag = lt;
      OP_LE, OP_GE: flag = !lt;
      default:      flag = 1'b0;
    endcase
  end

  // When WIDTH fills the last limb the overflow is the limb carry; otherwise it is bit WIDTH of the sum.
  if (WIDTH == EW) begin : g_full
    assign add_c = s[32];
  end else begin : g_part
    assign add_c = res_new[WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int i = 0; i < NLIMB; i++) begin
        a_l[i] <= a_ld[32*i +: 32];
        b_l[i] <= b_ld[32*i +: 32];
      end
    end else if (state_q == RUN) begin
      r_l[idx_q] <= s[31:0];
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      z_q     <= 1'b1;
      op_q    <= OP_ADD;
      sgn_q   <= 1'b0;
      y_q     <= '0;
      oc_q    <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= (bus.op != OP_ADD);
      z_q     <= 1'b1;
      op_q    <= bus.op;
      sgn_q   <= bus.is_signed;
    end else if (state_q == RUN) begin
      carry_q <= s[32];
      z_q     <= z_new;
      if (!last) begin
        idx_q <= idx_q + 1'b1;
      end else begin
        y_q  <= is_cmp ? WIDTH'(flag) : res_new[WIDTH-1:0];
        oc_q <= !sgn_q && ((op_q == OP_ADD) ? add_c : (op_q == OP_SUB) ? !s[32] : 1'b0);
      end
    end
  end
endmodule
